// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state type and
// wait-state counter limits.
package dmem_pkg;
  localparam int STATE_W  = 2;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder. Byte-lane write enables,
// combinational read; deliberately no reset so contents survive one.
module dmem_array #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            lane_en,
  input  logic [DEPTH_LOG2-1:0] index,
  input  logic [31:0]           din,
  output logic [31:0]           dout
);
  logic [31:0] mem [1<<DEPTH_LOG2];

  // Write only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_en[l]) mem[index][l*8 +: 8] <= din[l*8 +: 8];
      end
    end
  end

  assign dout = mem[index];
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU MEM stage: accepts one request in IDLE,
// waits WAIT_CYCLES, performs the access on entry to RESP and holds the
// response until the CPU takes it.
// Optional feature: define DMEM_BYTE_WRITE_EN to add the req_be port and
// per-byte store masking; otherwise every store writes the full word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [3:0]  req_be,
`endif
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [3:0]       be_q, be_d;

  logic        accept, enter_resp;
  logic        acc_we, acc_err, arr_we;
  logic [31:0] acc_addr, acc_wdata, acc_hi, arr_dout;
  logic [3:0]  acc_be, req_lanes;

`ifdef DMEM_BYTE_WRITE_EN
  assign req_lanes = req_be;
`else
  assign req_lanes = 4'hF;
`endif

  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With no wait states the access happens on the accepting edge, so it must
  // use the live request; otherwise it uses the captured copy.
  assign acc_we    = (state_q == ST_IDLE) ? req_we    : we_q;
  assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
  assign acc_be    = (state_q == ST_IDLE) ? req_lanes : be_q;

  assign acc_hi     = acc_addr >> (DEPTH_LOG2 + 2);
  assign acc_err    = (acc_addr[1:0] != 2'b00) || (acc_hi != '0);
  assign enter_resp = ((state_q == ST_IDLE) && accept && NO_WAIT) ||
                      ((state_q == ST_WAIT) && (cnt_q == '0));
  assign arr_we     = enter_resp && acc_we && !acc_err && !reset;

  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk    (clk),
    .we     (arr_we),
    .lane_en(acc_be),
    .index  (acc_addr[DEPTH_LOG2+1:2]),
    .din    (acc_wdata),
    .dout   (arr_dout)
  );

  // Next-state, request capture and response formation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_lanes;
          if (NO_WAIT) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_resp) begin
      rdata_d = (acc_we || acc_err) ? 32'h0 : arr_dout;
      err_d   = acc_err;
    end
  end

  // State and captured-request registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with WAIT_CYCLES=2 (sel 0) and one
// with WAIT_CYCLES=0 (sel 1), directed table, corner sequences and random
// traffic against a word-array reference model.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_we, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err, a_busy;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        b_req_valid, b_req_we, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]  a_req_be, b_req_be;
`endif

  dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
`ifdef DMEM_BYTE_WRITE_EN
    .req_be(a_req_be),
`endif
    .req_ready(a_req_ready), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .busy(a_busy));

  dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
`ifdef DMEM_BYTE_WRITE_EN
    .req_be(b_req_be),
`endif
    .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy));

  int checks = 0;
  int failures = 0;

  // Reference model: 64 words per instance, plus which words hold known data.
  logic [31:0] m_a [64];
  logic [31:0] m_b [64];
  bit          k_a [64];
  bit          k_b [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit f_ready(input int sel); return (sel == 0) ? a_req_ready : b_req_ready; endfunction
  function automatic bit f_valid(input int sel); return (sel == 0) ? a_rsp_valid : b_rsp_valid; endfunction
  function automatic bit f_busy (input int sel); return (sel == 0) ? a_busy : b_busy; endfunction
  function automatic bit f_err  (input int sel); return (sel == 0) ? a_rsp_err : b_rsp_err; endfunction
  function automatic logic [31:0] f_rdata(input int sel); return (sel == 0) ? a_rsp_rdata : b_rsp_rdata; endfunction

  task automatic drive(input int sel, input logic v, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    if (sel == 0) begin
      a_req_valid = v; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
`ifdef DMEM_BYTE_WRITE_EN
      a_req_be = be;
`endif
    end else begin
      b_req_valid = v; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata;
`ifdef DMEM_BYTE_WRITE_EN
      b_req_be = be;
`endif
    end
  endtask

  task automatic set_rsp_ready(input int sel, input logic r);
    if (sel == 0) a_rsp_ready = r; else b_rsp_ready = r;
  endtask

  // Expected response from the memory rules; updates the model on good stores.
  task automatic model(input int sel, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] e_rd, output logic e_err, output bit e_known);
    int idx;
    logic [31:0] cur;
    logic [3:0] lanes;
    bit kn;
    e_err = (addr % 4 != 0) || (addr >= 32'h100);
    idx = int'(addr / 4) % 64;
    e_rd = 32'h0;
    e_known = 1'b1;
`ifdef DMEM_BYTE_WRITE_EN
    lanes = be;
`else
    lanes = 4'hF;
`endif
    cur = (sel == 0) ? m_a[idx] : m_b[idx];
    kn  = (sel == 0) ? k_a[idx] : k_b[idx];
    if (!e_err) begin
      if (we) begin
        for (int l = 0; l < 4; l++) if (lanes[l]) cur[l*8 +: 8] = wdata[l*8 +: 8];
        if (lanes == 4'hF) kn = 1'b1;
        if (sel == 0) begin m_a[idx] = cur; k_a[idx] = kn; end
        else          begin m_b[idx] = cur; k_b[idx] = kn; end
      end else begin
        e_rd = cur;
        e_known = kn;
      end
    end
  endtask

  // One full transaction: latency, stability under back-pressure, completion.
  task automatic txn(input int sel, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold, output logic [31:0] rd, output logic er);
    int w, lat, n;
    logic [31:0] e_rd;
    logic e_err;
    bit e_known;
    w = (sel == 0) ? 2 : 0;
    drive(sel, 1'b1, we, addr, wdata, be);
    n = 0;
    while (!f_ready(sel) && n < 20) begin @(posedge clk); #1; n++; end
    chk("req_ready_before_accept", 32'(f_ready(sel)), 32'd1);
    @(posedge clk); #1;
    model(sel, we, addr, wdata, be, e_rd, e_err, e_known);
    drive(sel, 1'b0, ~we, $urandom, $urandom, 4'($urandom));
    lat = 1;
    while (!f_valid(sel) && lat < 40) begin
      chk("wait_outputs", {f_busy(sel), f_ready(sel), f_rdata(sel) == 32'h0}, {1'b1, 1'b0, 1'b1});
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(w + 1));
    chk("resp_busy", {f_busy(sel), f_ready(sel)}, {1'b1, 1'b0});
    rd = f_rdata(sel);
    er = f_err(sel);
    chk("rsp_err", 32'(er), 32'(e_err));
    if (e_known) begin
      checks++;
      if (rd !== e_rd) begin
        failures++;
        $display("FAIL rsp_rdata actual=%h expected=%h addr=%h we=%b be=%h", rd, e_rd, addr, we, be);
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_stable", {f_valid(sel), f_ready(sel), f_err(sel), f_rdata(sel)}, {1'b1, 1'b0, er, rd});
    end
    set_rsp_ready(sel, 1'b1);
    @(posedge clk); #1;
    set_rsp_ready(sel, 1'b0);
    chk("complete", {f_busy(sel), f_valid(sel), f_ready(sel), f_err(sel), f_rdata(sel)},
        {1'b0, 1'b0, 1'b1, 1'b0, 32'h0});
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [31:0] rd;
    logic er;
    tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h10,       32'h0,        4'hF, 0, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h0,        32'h00000055, 4'hF, 1, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 32'h102,      32'hFFFFFFFF, 4'hF, 0, 1'b1, 32'h0};
    tbl[4]  = '{1'b1, 32'h100,      32'hEEEEEEEE, 4'hF, 0, 1'b1, 32'h0};
    tbl[5]  = '{1'b0, 32'h0,        32'h0,        4'hF, 0, 1'b0, 32'h00000055};
    tbl[6]  = '{1'b0, 32'h10,       32'h0,        4'hF, 4, 1'b0, 32'hDEADBEEF};
    tbl[7]  = '{1'b0, 32'h103,      32'h0,        4'hF, 0, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 32'hFC,       32'h0BADF00D, 4'hF, 2, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 32'hFC,       32'h0,        4'hF, 0, 1'b0, 32'h0BADF00D};
    tbl[10] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'hF, 0, 1'b1, 32'h0};
    tbl[11] = '{1'b0, 32'h80000000, 32'h0,        4'hF, 0, 1'b1, 32'h0};

    for (int i = 0; i < 64; i++) begin m_a[i] = 32'h0; m_b[i] = 32'h0; k_a[i] = 1'b0; k_b[i] = 1'b0; end
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    a_rsp_ready = 1'b0;
    b_rsp_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("reset_a", {a_busy, a_rsp_valid, a_rsp_err, a_req_ready, a_rsp_rdata}, {1'b0, 1'b0, 1'b0, 1'b1, 32'h0});
    chk("reset_b", {b_busy, b_rsp_valid, b_rsp_err, b_req_ready, b_rsp_rdata}, {1'b0, 1'b0, 1'b0, 1'b1, 32'h0});
    @(posedge clk); #1;

    // Directed table on both wait-state configurations.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 12; i++) begin
        txn(s, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].hold, rd, er);
        chk($sformatf("tbl%0d_s%0d_err", i, s), 32'(er), 32'(tbl[i].exp_err));
        chk($sformatf("tbl%0d_s%0d_rdata", i, s), rd, tbl[i].exp_rd);
      end
    end

    // Reset while a store sits in WAIT: outputs drop at once, no write lands.
    txn(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, rd, er);
    drive(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("in_wait_busy", 32'(a_busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_out", {a_busy, a_rsp_valid, a_rsp_err, a_rsp_rdata}, {1'b0, 1'b0, 1'b0, 32'h0});
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er);
    chk("reset_no_write", rd, 32'hCAFEF00D);

`ifdef DMEM_BYTE_WRITE_EN
    for (int s = 0; s < 2; s++) begin
      txn(s, 1'b1, 32'h30, 32'h11111111, 4'hF, 0, rd, er);
      txn(s, 1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, 0, rd, er);
      txn(s, 1'b0, 32'h30, 32'h0, 4'hF, 0, rd, er);
      chk("byte_merge", rd, 32'h11BB11DD);
      txn(s, 1'b1, 32'h30, 32'h99999999, 4'b0000, 0, rd, er);
      chk("be0_err", 32'(er), 32'd0);
      txn(s, 1'b0, 32'h30, 32'h0, 4'hF, 0, rd, er);
      chk("be0_noop", rd, 32'h11BB11DD);
    end
`endif

    // Random traffic checked inside txn against the model.
    for (int i = 0; i < 120; i++) begin
      int r;
      logic [31:0] addr;
      r = $urandom_range(0, 9);
      if (r < 8)       addr = 32'($urandom_range(0, 63)) * 4;
      else if (r == 8) addr = 32'($urandom_range(0, 255)) | 32'h1;
      else             addr = $urandom | 32'h100;
      txn(i % 2, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 3), rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
